// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA timing generator and its decoder.
package vga_pkg;

  localparam int COLOR_W         = 8;
  localparam int H_ACTIVE_DEF    = 640;
  localparam int H_TOTAL_DEF     = 800;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int V_TOTAL_DEF     = 525;
  localparam int LOCK_FRAMES_DEF = 2;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } dec_state_t;

endpackage

// File: rtl/edge_detect.sv
// Captures one asynchronous-to-logic level and reports registered rise/fall pulses.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dly,
  output logic rise,
  output logic fall
);

  logic cap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cap  <= 1'b0;
      dly  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cap  <= din;
      dly  <= cap;
      rise <= cap & ~dly;
      fall <= ~cap & dly;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixels and x/y from a sampled VGA bus, measures line/frame geometry,
// and tracks lock against the expected mode.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               vga_clk,
  input  logic               vga_hs,
  input  logic               vga_vs,
  input  logic               vga_blank_n,
  input  logic [COLOR_W-1:0] vga_r,
  input  logic [COLOR_W-1:0] vga_g,
  input  logic [COLOR_W-1:0] vga_b,
  output logic               pix_valid,
  output logic [9:0]         pix_x,
  output logic [9:0]         pix_y,
  output logic [COLOR_W-1:0] pix_r,
  output logic [COLOR_W-1:0] pix_g,
  output logic [COLOR_W-1:0] pix_b,
  output logic               frame_start,
  output logic               locked,
  output logic               err_h,
  output logic               err_v
);

  localparam int NUM_SIG = 4;
  localparam int GF_W    = $clog2(LOCK_FRAMES + 1);

  localparam logic [10:0]     H_TOTAL_C  = H_TOTAL[10:0];
  localparam logic [9:0]      H_ACTIVE_C = H_ACTIVE[9:0];
  localparam logic [10:0]     V_TOTAL_C  = V_TOTAL[10:0];
  localparam logic [9:0]      V_ACTIVE_C = V_ACTIVE[9:0];
  localparam logic [GF_W-1:0] GF_LOCK    = LOCK_FRAMES[GF_W-1:0];

  // Lane order: 0 pixel clock, 1 HS, 2 VS, 3 blank_n.
  logic [NUM_SIG-1:0] sig_in, sig_dly, sig_rise, sig_fall;
  assign sig_in = {vga_blank_n, vga_vs, vga_hs, vga_clk};

  for (genvar i = 0; i < NUM_SIG; i++) begin : g_edge
    edge_detect u_edge (
      .clk  (CLOCK_50),
      .reset(reset),
      .din  (sig_in[i]),
      .dly  (sig_dly[i]),
      .rise (sig_rise[i]),
      .fall (sig_fall[i])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{sig_rise[3:1], sig_fall[3], sig_fall[0], sig_dly[2:0]};

  logic ps, hs_fall, vs_fall, blank_q;
  assign ps      = sig_rise[0];
  assign hs_fall = sig_fall[1];
  assign vs_fall = sig_fall[2];
  assign blank_q = sig_dly[3];

  logic [3*COLOR_W-1:0] rgb_q1, rgb_q2;
  logic [10:0]          h_cnt, v_cnt, v_next;
  logic [9:0]           x_cnt, y_cnt, y_next;
  logic [GF_W-1:0]      gf, gf_n;
  logic                 skip_h, h_bad, v_bad, searching;
  dec_state_t           st;

  assign searching = (st == ST_SEARCH);
  assign gf_n      = gf + 1'b1;

  // Vertical blanking lines carry no active pixels, so an empty line is not an error.
  always_comb begin
    y_next = y_cnt;
    v_next = v_cnt;
    if (hs_fall && (x_cnt != 10'd0) && !(&y_cnt)) y_next = y_cnt + 10'd1;
    if (hs_fall && !(&v_cnt))                      v_next = v_cnt + 11'd1;
    h_bad = hs_fall && !skip_h &&
            ((h_cnt != H_TOTAL_C) || ((x_cnt != 10'd0) && (x_cnt != H_ACTIVE_C)));
    v_bad = vs_fall && ((v_next != V_TOTAL_C) || (y_next != V_ACTIVE_C));
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      rgb_q1      <= '0;
      rgb_q2      <= '0;
      h_cnt       <= '0;
      x_cnt       <= '0;
      v_cnt       <= '0;
      y_cnt       <= '0;
      gf          <= '0;
      skip_h      <= 1'b0;
      st          <= ST_SEARCH;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
    end else begin
      rgb_q1 <= {vga_r, vga_g, vga_b};
      rgb_q2 <= rgb_q1;

      // A strobe coinciding with the clearing edge belongs to the new line.
      if (hs_fall || (searching && vs_fall)) begin
        h_cnt <= ps ? 11'd1 : 11'd0;
        x_cnt <= (ps && blank_q) ? 10'd1 : 10'd0;
      end else begin
        if (ps && !(&h_cnt))            h_cnt <= h_cnt + 11'd1;
        if (ps && blank_q && !(&x_cnt)) x_cnt <= x_cnt + 10'd1;
      end

      if (vs_fall) begin
        v_cnt <= '0;
        y_cnt <= '0;
      end else begin
        v_cnt <= v_next;
        y_cnt <= y_next;
      end

      if (searching && vs_fall) skip_h <= 1'b1;
      else if (hs_fall)         skip_h <= 1'b0;

      pix_valid <= ps && blank_q && !searching;
      if (ps && blank_q && !searching) begin
        pix_x                 <= x_cnt;
        pix_y                 <= y_cnt;
        {pix_r, pix_g, pix_b} <= rgb_q2;
      end

      frame_start <= vs_fall;
      err_h       <= h_bad && !searching;
      err_v       <= v_bad && !searching;
      locked      <= (st == ST_LOCKED);

      case (st)
        ST_SEARCH: begin
          if (vs_fall) begin
            st <= ST_MEASURE;
            gf <= '0;
          end
        end
        ST_MEASURE: begin
          if (h_bad || v_bad) begin
            st <= ST_SEARCH;
          end else if (vs_fall) begin
            gf <= gf_n;
            if (gf_n == GF_LOCK) st <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (h_bad || v_bad) st <= ST_SEARCH;
        end
        default: st <= ST_SEARCH;
      endcase
    end
  end

endmodule
